// File: rtl/v_lane_sched_if.sv
// v_lane_sched_if: op request, configuration and per-beat strobe bundle for the lane sequencer
interface v_lane_sched_if;
  logic       start_i;
  logic       ready_o;
  logic [3:0] op_instr_alu;
  logic       is_mul;
  logic [2:0] lmul;
  logic [1:0] lanes;
  logic       issue_valid_o;
  logic [1:0] issue_step_o;
  logic [3:0] grp_en_o;
  logic [3:0] cap_en_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  modport master (
    output start_i, op_instr_alu, is_mul, lmul, lanes,
    input  ready_o, issue_valid_o, issue_step_o, grp_en_o, cap_en_o, busy_o, done_o, err_o
  );
  modport slave (
    input  start_i, op_instr_alu, is_mul, lmul, lanes,
    output ready_o, issue_valid_o, issue_step_o, grp_en_o, cap_en_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/v_lane_sched.sv
// v_lane_sched: splits one vector op into 128b chunks and sequences issue/wait/capture beats
module v_lane_sched #(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  v_lane_sched_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DONE} state_t;
  state_t     state;
  logic [1:0] b, lmul_q, lanes_q, g_log, g_in;
  logic       mul_q, illegal, last;
  logic [7:0] cnt, lat_m1;
  logic [2:0] nb_m1;
  logic [3:0] mask_in, cap;
  // groups/beat is a power of two, so everything works on log2(G) = min(lanes, lmul)
  always_comb begin
    g_in    = (bus.lanes < bus.lmul[1:0]) ? bus.lanes : bus.lmul[1:0];
    mask_in = g_in == 2'd0 ? 4'h1 : g_in == 2'd1 ? 4'h3 : 4'hf;
    illegal = bus.lmul > 3'd2 || bus.lanes == 2'd3 || (bus.op_instr_alu == 4'd0 && !bus.is_mul);
    g_log   = lanes_q < lmul_q ? lanes_q : lmul_q;
    nb_m1   = (3'd1 << (lmul_q - g_log)) - 3'd1;
    last    = {1'b0, b} == nb_m1;
    cap     = bus.grp_en_o << ({2'b0, b} << g_log);
    lat_m1  = mul_q ? 8'(MUL_LAT - 1) : 8'(ALU_LAT - 1);
  end
  assign bus.issue_step_o = b;
  assign bus.busy_o       = ~bus.ready_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bus.ready_o       <= 1'b1;
      bus.issue_valid_o <= 1'b0;
      bus.grp_en_o      <= '0;
      bus.cap_en_o      <= '0;
      bus.done_o        <= 1'b0;
      bus.err_o         <= 1'b0;
      b                 <= '0;
      cnt               <= '0;
      lmul_q            <= '0;
      lanes_q           <= '0;
      mul_q             <= 1'b0;
    end else begin
      bus.issue_valid_o <= 1'b0;
      bus.cap_en_o      <= '0;
      bus.done_o        <= 1'b0;
      bus.err_o         <= 1'b0;
      case (state)
        IDLE: if (bus.start_i) begin
          if (illegal) bus.err_o <= 1'b1;
          else begin
            state             <= ISSUE;
            bus.ready_o       <= 1'b0;
            bus.issue_valid_o <= 1'b1;
            bus.grp_en_o      <= mask_in;
            b                 <= '0;
            lmul_q            <= bus.lmul[1:0];
            lanes_q           <= bus.lanes;
            mul_q             <= bus.is_mul;
          end
        end
        ISSUE: if (lat_m1 == 8'd0) begin
          state        <= CAPT;
          bus.cap_en_o <= cap;
        end else begin
          state <= WAIT;
          cnt   <= lat_m1;
        end
        WAIT: if (cnt == 8'd1) begin
          state        <= CAPT;
          bus.cap_en_o <= cap;
        end else cnt <= cnt - 8'd1;
        CAPT: if (last) begin
          state        <= DONE;
          bus.done_o   <= 1'b1;
          bus.grp_en_o <= '0;
          b            <= '0;
        end else begin
          state             <= ISSUE;
          bus.issue_valid_o <= 1'b1;
          b                 <= b + 2'd1;
        end
        default: begin
          state       <= IDLE;
          bus.ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_v_lane_sched.sv
// tb_v_lane_sched: directed cycle-accurate checks of beat sequencing, illegal configs and reset
module tb_v_lane_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  v_lane_sched_if bus();
  v_lane_sched dut (.clk(clk), .rst(rst), .bus(bus));
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] op, input logic m, input logic [2:0] lm, input logic [1:0] ln);
    bus.op_instr_alu = op;
    bus.is_mul = m;
    bus.lmul = lm;
    bus.lanes = ln;
  endtask

  // accept at c0, keep start_i high while busy, scramble config after accept
  task automatic run(input string n, input logic [3:0] op, input logic m, input logic [2:0] lm,
                     input logic [1:0] ln, input int e_done, input logic [15:0] e_caps,
                     input logic [7:0] e_steps, input int e_iss, input logic [3:0] e_grp,
                     input int e_first, input int e_last);
    int done_cyc = 0, iss = 0, ncap = 0, first = 0, lastc = 0;
    logic [15:0] caps = '0;
    logic [7:0] steps = '0;
    logic [3:0] grp = '0;
    logic err_seen = 1'b0;
    cfg(op, m, lm, ln);
    bus.start_i = 1'b1;
    tick();
    cfg(4'd9, ~m, 3'd0, 2'd2);
    for (int c = 1; c <= 40; c++) begin
      if (bus.issue_valid_o) begin
        steps = steps | (8'(bus.issue_step_o) << (2 * iss));
        grp = bus.grp_en_o;
        iss++;
      end
      if (bus.cap_en_o != 4'd0) begin
        caps = caps | (16'(bus.cap_en_o) << (4 * ncap));
        ncap++;
        if (first == 0) first = c;
        lastc = c;
      end
      err_seen = err_seen | bus.err_o;
      if (bus.done_o) begin
        done_cyc = c;
        chk({n, ".grp_at_done"}, 32'(bus.grp_en_o), 32'd0);
        break;
      end
      tick();
    end
    bus.start_i = 1'b0;
    chk({n, ".done_cycle"}, done_cyc, e_done);
    chk({n, ".caps"}, 32'(caps), 32'(e_caps));
    chk({n, ".steps"}, 32'(steps), 32'(e_steps));
    chk({n, ".issues"}, iss, e_iss);
    chk({n, ".grp"}, 32'(grp), 32'(e_grp));
    chk({n, ".first_cap"}, first, e_first);
    chk({n, ".last_cap"}, lastc, e_last);
    chk({n, ".no_err"}, 32'(err_seen), 32'd0);
    tick();
    chk({n, ".ready_after"}, 32'(bus.ready_o), 32'd1);
    chk({n, ".busy_after"}, 32'(bus.busy_o), 32'd0);
    chk({n, ".done_gone"}, 32'(bus.done_o), 32'd0);
  endtask

  task automatic ill(input string n, input logic [3:0] op, input logic m, input logic [2:0] lm, input logic [1:0] ln);
    cfg(op, m, lm, ln);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk({n, ".err"}, 32'(bus.err_o), 32'd1);
    chk({n, ".ready"}, 32'(bus.ready_o), 32'd1);
    chk({n, ".no_issue"}, 32'(bus.issue_valid_o), 32'd0);
    tick();
    chk({n, ".err_pulse"}, 32'(bus.err_o), 32'd0);
    chk({n, ".no_issue2"}, 32'(bus.issue_valid_o), 32'd0);
    chk({n, ".no_done"}, 32'(bus.done_o), 32'd0);
    chk({n, ".ready2"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    bus.start_i = 1'b0;
    cfg(4'd1, 1'b0, 3'd0, 2'd0);
    tick();
    tick();
    chk("rst.ready", 32'(bus.ready_o), 32'd1);
    chk("rst.busy", 32'(bus.busy_o), 32'd0);
    chk("rst.issue", 32'(bus.issue_valid_o), 32'd0);
    chk("rst.step", 32'(bus.issue_step_o), 32'd0);
    chk("rst.grp", 32'(bus.grp_en_o), 32'd0);
    chk("rst.cap", 32'(bus.cap_en_o), 32'd0);
    chk("rst.done", 32'(bus.done_o), 32'd0);
    chk("rst.err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;
    tick();
    run("T1", 4'd3, 1'b0, 3'd0, 2'd0, 3, 16'h0001, 8'h00, 1, 4'h1, 2, 2);
    run("T2", 4'd0, 1'b1, 3'd2, 2'd0, 13, 16'h8421, 8'he4, 4, 4'h1, 3, 12);
    run("T3", 4'd2, 1'b0, 3'd2, 2'd1, 5, 16'h00c3, 8'h04, 2, 4'h3, 2, 4);
    run("T4", 4'd2, 1'b0, 3'd1, 2'd2, 3, 16'h0003, 8'h00, 1, 4'h3, 2, 2);
    run("T4b", 4'd0, 1'b1, 3'd0, 2'd2, 4, 16'h0001, 8'h00, 1, 4'h1, 3, 3);
    run("T4c", 4'd7, 1'b0, 3'd2, 2'd2, 3, 16'h000f, 8'h00, 1, 4'hf, 2, 2);
    ill("T5.lanes3", 4'd1, 1'b0, 3'd0, 2'd3);
    ill("T5.lmul3", 4'd1, 1'b0, 3'd3, 2'd0);
    ill("T5.noop", 4'd0, 1'b0, 3'd1, 2'd1);
    cfg(4'd0, 1'b1, 3'd2, 2'd0);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    chk("T6.cap0", 32'(bus.cap_en_o), 32'h1);
    tick();
    chk("T6.issue1", 32'(bus.issue_valid_o), 32'd1);
    chk("T6.step1", 32'(bus.issue_step_o), 32'd1);
    tick();
    chk("T6.wait_step", 32'(bus.issue_step_o), 32'd1);
    chk("T6.wait_grp", 32'(bus.grp_en_o), 32'h1);
    chk("T6.wait_noissue", 32'(bus.issue_valid_o), 32'd0);
    rst = 1'b1;
    tick();
    chk("T6.ready", 32'(bus.ready_o), 32'd1);
    chk("T6.busy", 32'(bus.busy_o), 32'd0);
    chk("T6.grp", 32'(bus.grp_en_o), 32'd0);
    chk("T6.cap", 32'(bus.cap_en_o), 32'd0);
    chk("T6.step", 32'(bus.issue_step_o), 32'd0);
    chk("T6.done", 32'(bus.done_o), 32'd0);
    rst = 1'b0;
    tick();
    chk("T6.idle_cap", 32'(bus.cap_en_o), 32'd0);
    chk("T6.idle_done", 32'(bus.done_o), 32'd0);
    run("T6.fresh", 4'd3, 1'b0, 3'd0, 2'd0, 3, 16'h0001, 8'h00, 1, 4'h1, 2, 2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
